// File: rtl/tdsp_data_bus_resp.sv
// Responder end of the TDSP data-memory bus: grant arbiter between the core and one
// external agent, core access FSM with programmable wait states, and the data RAM.
module tdsp_data_bus_resp #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bus_request,
   output logic              bus_grant,
   input  logic              as,
   input  logic              read,
   input  logic              write,
   input  logic              write_h,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   input  logic              ext_req,
   output logic              ext_grant,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ready,
   output logic              err
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_HOLD} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              as_d;
   logic [2:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              is_wr_q;
   logic              prio_ext;
   logic              start;
   logic              core_ok;
   logic              ext_ok;
   logic              ext_acc;
   logic              cap_ok;
   logic [DATA_W-1:0] ram [DEPTH];

   assign core_ok = ({1'b0, addr_q}   < DEPTH_L);
   assign ext_ok  = ({1'b0, ext_addr} < DEPTH_L);
   assign cap_ok  = ({1'b0, address}  < DEPTH_L);
   assign ext_acc = ext_grant && ext_req;

   // Arbiter: grants are exclusive, core wins the first tie after reset, then ties alternate
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_grant <= 1'b0;
         ext_grant <= 1'b0;
         prio_ext  <= 1'b0;
      end else if (!bus_grant && !ext_grant) begin
         if (bus_request && ext_req) begin
            bus_grant <= !prio_ext;
            ext_grant <= prio_ext;
            prio_ext  <= !prio_ext;
         end else begin
            bus_grant <= bus_request;
            ext_grant <= ext_req;
         end
      end else if (bus_grant) begin
         // an access starting this cycle keeps the grant until it returns to idle
         if (!bus_request && (state == S_IDLE) && !start)
            bus_grant <= 1'b0;
      end else if (!ext_req) begin
         ext_grant <= 1'b0;
      end
   end

   // Core access state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Core access next state: one access per as-high period, as low in WAIT aborts
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus_grant && as && !as_d) begin
               start     = 1'b1;
               state_nxt = (WAIT_STATES == 0) ? S_XFER : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!as)              state_nxt = S_IDLE;
            else if (cnt <= 3'd1) state_nxt = S_XFER;
         end
         S_XFER: state_nxt = S_HOLD;
         S_HOLD: begin
            if (!as && !write_h) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Access capture, wait counter, read data, ready pulse and sticky error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         as_d    <= 1'b0;
         cnt     <= '0;
         addr_q  <= '0;
         is_wr_q <= 1'b0;
         rd_data <= '0;
         ready   <= 1'b0;
         err     <= 1'b0;
      end else begin
         as_d  <= as;
         ready <= 1'b0;
         if (start) begin
            addr_q  <= address;
            is_wr_q <= write && !read;
            cnt     <= 3'(WAIT_STATES);
            if ((read && write) || !cap_ok) err <= 1'b1;
         end
         if (state == S_WAIT) cnt <= cnt - 3'd1;
         if (state == S_XFER) begin
            ready <= 1'b1;
            if (!is_wr_q) rd_data <= core_ok ? ram[addr_q[IDX_W-1:0]] : '0;
         end
         if (ext_acc) begin
            ready <= 1'b1;
            if (!ext_we) rd_data <= ext_ok ? ram[ext_addr[IDX_W-1:0]] : '0;
            if (!ext_ok) err <= 1'b1;
         end
      end
   end

   // RAM write port, shared by the core commit and external writes (never concurrent)
   always_ff @(posedge clk) begin
      if ((state == S_XFER) && is_wr_q && core_ok)
         ram[addr_q[IDX_W-1:0]] <= wr_data;
      else if (ext_acc && ext_we && ext_ok)
         ram[ext_addr[IDX_W-1:0]] <= ext_wdata;
   end

endmodule

// File: tb/tb_tdsp_data_bus_resp.sv
// Directed plus randomized bench for tdsp_data_bus_resp against a word-array memory model.
module tb_tdsp_data_bus_resp;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DEPTH  = 256;
   localparam int unsigned WS     = 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              bus_request;
   logic              bus_grant;
   logic              as;
   logic              read;
   logic              write;
   logic              write_h;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              ext_req;
   logic              ext_grant;
   logic              ext_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ready;
   logic              err;

   int total = 0;
   int bad   = 0;

   logic [15:0] mem [256];
   bit          prio_ext_m = 1'b0;
   bit          err_m      = 1'b0;

   tdsp_data_bus_resp #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH(DEPTH),
      .WAIT_STATES(WS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus_request(bus_request),
      .bus_grant(bus_grant),
      .as(as),
      .read(read),
      .write(write),
      .write_h(write_h),
      .address(address),
      .wr_data(wr_data),
      .rd_data(rd_data),
      .ext_req(ext_req),
      .ext_grant(ext_grant),
      .ext_we(ext_we),
      .ext_addr(ext_addr),
      .ext_wdata(ext_wdata),
      .ready(ready),
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input bit to_ext);
      int n = 0;
      while (((to_ext ? ext_grant : bus_grant) !== 1'b1) && n < 10) begin
         tick();
         n++;
      end
      if (to_ext) chk("ext_grant_wait", ext_grant, 1);
      else        chk("core_grant_wait", bus_grant, 1);
   endtask

   // One core access: as held until ready, then dropped; returns edges-to-ready
   task automatic core_access(input logic rd_i, input logic wr_i, input logic [8:0] a,
                              input logic [15:0] d, output int lat,
                              output logic [15:0] rdv, output logic rdy_after);
      address = a;
      wr_data = d;
      read    = rd_i;
      write   = wr_i;
      as      = 1'b1;
      lat     = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         lat++;
         if (ready === 1'b1) break;
      end
      rdv   = rd_data;
      as    = 1'b0;
      read  = 1'b0;
      write = 1'b0;
      tick();
      rdy_after = ready;
   endtask

   task automatic do_core(input logic rd_i, input logic wr_i, input logic [8:0] a,
                          input logic [15:0] d);
      int          lat;
      logic [15:0] rdv;
      logic        ra;
      logic [15:0] exp;
      core_access(rd_i, wr_i, a, d, lat, rdv, ra);
      chk("core_latency", lat, WS + 2);
      chk("ready_single_pulse", ra, 0);
      if (rd_i || !wr_i) begin
         exp = (a < 9'(DEPTH)) ? mem[a[7:0]] : 16'h0000;
         chk("core_rdata", rdv, exp);
      end else if (a < 9'(DEPTH)) begin
         mem[a[7:0]] = d;
      end
      if (a >= 9'(DEPTH) || (rd_i && wr_i)) err_m = 1'b1;
      chk("err_flag", err, err_m);
   endtask

   initial begin
      logic        wr;
      logic [8:0]  a;
      logic [15:0] d;
      int          rcnt;

      reset = 1'b0; bus_request = 1'b0; as = 1'b0; read = 1'b0; write = 1'b0;
      write_h = 1'b0; address = '0; wr_data = '0; ext_req = 1'b0; ext_we = 1'b0;
      ext_addr = '0; ext_wdata = '0;

      // reset state
      tick(); tick();
      chk("rst_grants", {bus_grant, ext_grant}, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_ready_err", {ready, err}, 0);
      reset = 1'b1;
      tick();

      // single request granted one cycle later
      bus_request = 1'b1;
      tick();
      chk("req_core_grant", bus_grant, 1);
      chk("req_core_no_ext", ext_grant, 0);

      // write then read back with wait-state latency
      do_core(1'b0, 1'b1, 9'h005, 16'h1234);
      do_core(1'b1, 1'b0, 9'h005, 16'h0000);
      chk("rd_0x05", mem[5], 16'h1234);

      // write aborted in WAIT leaves memory untouched and gives no ready
      do_core(1'b0, 1'b1, 9'h007, 16'hAAAA);
      address = 9'h007; wr_data = 16'h5555; write = 1'b1; as = 1'b1;
      tick();
      as = 1'b0; write = 1'b0;
      rcnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ready === 1'b1) rcnt++;
      end
      chk("abort_no_ready", rcnt, 0);
      do_core(1'b1, 1'b0, 9'h007, 16'h0000);

      // two contentions: core first, then external
      bus_request = 1'b0;
      tick(); tick();
      chk("release_idle", {bus_grant, ext_grant}, 0);
      bus_request = 1'b1; ext_req = 1'b1;
      tick();
      chk("cont1_core", bus_grant, {31'b0, !prio_ext_m});
      chk("cont1_ext", ext_grant, {31'b0, prio_ext_m});
      prio_ext_m = !prio_ext_m;
      bus_request = 1'b0;
      tick();
      chk("core_release", bus_grant, 0);
      tick();
      chk("ext_after_release", ext_grant, 1);
      ext_req = 1'b0;
      tick(); tick();
      chk("ext_release", {bus_grant, ext_grant}, 0);
      bus_request = 1'b1; ext_req = 1'b1;
      tick();
      chk("cont2_core", bus_grant, {31'b0, !prio_ext_m});
      chk("cont2_ext", ext_grant, {31'b0, prio_ext_m});
      prio_ext_m = !prio_ext_m;
      bus_request = 1'b0;
      wait_grant(1'b1);

      // external fill of the whole RAM, one write per cycle
      for (int i = 0; i < 256; i++) begin
         ext_we = 1'b1; ext_addr = 9'(i); ext_wdata = 16'($urandom);
         tick();
         mem[i] = ext_wdata;
         chk("ext_wr_ready", ready, 1);
      end
      // external random reads
      for (int i = 0; i < 32; i++) begin
         ext_we = 1'b0; a = 9'($urandom_range(0, 255)); ext_addr = a;
         tick();
         chk("ext_rd_ready", ready, 1);
         chk("ext_rd_data", rd_data, mem[a[7:0]]);
      end
      ext_req = 1'b0; ext_we = 1'b0;
      tick();
      bus_request = 1'b1;
      wait_grant(1'b0);

      // core random mix
      for (int i = 0; i < 24; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = 9'($urandom_range(0, 255));
         d  = 16'($urandom);
         do_core(!wr, wr, a, d);
      end

      // out-of-range: read gives 0, write suppressed (no alias onto word 0)
      do_core(1'b1, 1'b0, 9'h005, 16'h0000);
      do_core(1'b1, 1'b0, 9'h100, 16'h0000);
      do_core(1'b0, 1'b1, 9'h100, 16'hDEAD);
      do_core(1'b1, 1'b0, 9'h000, 16'h0000);

      // reset asserted while the access sits in XFER
      do_core(1'b1, 1'b0, 9'h005, 16'h0000);
      address = 9'h009; wr_data = ~mem[9]; write = 1'b1; as = 1'b1;
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      chk("midrst_grants", {bus_grant, ext_grant}, 0);
      chk("midrst_rd_data", rd_data, 0);
      chk("midrst_ready", ready, 0);
      chk("midrst_err", err, 0);
      err_m = 1'b0;
      prio_ext_m = 1'b0;
      as = 1'b0; write = 1'b0;
      tick();
      reset = 1'b1;
      wait_grant(1'b0);
      chk("post_rst_no_ready", ready, 0);
      do_core(1'b1, 1'b0, 9'h009, 16'h0000);

      // read and write both high: treated as read, error raised
      do_core(1'b1, 1'b1, 9'h005, 16'h4321);
      do_core(1'b1, 1'b0, 9'h005, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
